// File: rtl/wa_dot_acc.sv
// Dot-product accumulator behind the 8x8 Wallace multiplier: sums unsigned
// products per vector and hands the saturated result out over valid/ready.
module wa_dot_acc #(
    parameter int PROD_W = 17,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic               accept_s;
    logic [ACC_W:0]     sum_ext_s;
    logic [ACC_W-1:0]   acc_n_s;
    logic [CNT_W-1:0]   cnt_n_s;
    logic               ovf_n_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC: begin
                if (accept_s && in_last) begin
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_OUT: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // Output decode from state
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            ST_ACC:  in_ready = 1'b1;
            ST_OUT:  in_ready = 1'b0;
            default: in_ready = 1'b0;
        endcase
    end

    // Saturating accumulate of the presented term; once overflowed, the vector stays pinned at all-ones
    always_comb begin
        accept_s  = in_valid && in_ready;
        sum_ext_s = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
        if (sum_ext_s[ACC_W] || ovf_q) begin
            acc_n_s = {ACC_W{1'b1}};
            ovf_n_s = 1'b1;
        end else begin
            acc_n_s = sum_ext_s[ACC_W-1:0];
            ovf_n_s = 1'b0;
        end
        if (cnt_q == {CNT_W{1'b1}}) begin
            cnt_n_s = cnt_q;
        end else begin
            cnt_n_s = cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
        end
    end

    // Datapath next values
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        if (accept_s) begin
            if (in_last) begin
                out_sum_d   = acc_n_s;
                out_count_d = cnt_n_s;
                out_ovf_d   = ovf_n_s;
                out_valid_d = 1'b1;
                acc_d       = {ACC_W{1'b0}};
                cnt_d       = {CNT_W{1'b0}};
                ovf_d       = 1'b0;
            end else begin
                acc_d = acc_n_s;
                cnt_d = cnt_n_s;
                ovf_d = ovf_n_s;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= {ACC_W{1'b0}};
            out_count_q <= {CNT_W{1'b0}};
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule
